edge_event_fifo: RTL
====================

# edge_event_fifo

Downstream consumer of the per-bit rising-edge detector. Each clock where the detector's `pedge` vector is nonzero becomes one time-stamped event record in a small FIFO, which a reader drains over a valid/ready handshake. Events arriving while the FIFO is full are dropped and counted, so the reader knows edges were lost.

## Interface
- `WIDTH`, 8: width of the `pedge` vector and of each stored mask.
- `DEPTH`, 8: FIFO entries; a power of two, at least 2.
- `TS_W`, 16: timestamp width.

- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pedge`  in  WIDTH: one-cycle edge pulses from the edge detector, sampled every cycle.
- `out_valid`  out  1: the head record is available.
- `out_ready`  in  1: the reader accepts the head record.
- `out_mask`  out  WIDTH: `pedge` value of the head record.
- `out_ts`  out  TS_W: timestamp of the head record.
- `level`  out  $clog2(DEPTH)+1: number of stored records, 0..DEPTH.
- `overflow`  out  1: sticky flag; at least one event was dropped.
- `drop_cnt`  out  8: count of dropped events, saturating at 255.
- `ovf_clr`  in  1: one-cycle pulse that clears `overflow` and `drop_cnt`.

## Operation
- **Timestamp.** `ts` is a free-running TS_W-bit counter.
  - It is 0 in the first cycle after `rst` deasserts and increments every cycle.
  - It wraps from 2^TS_W−1 to 0 with no flag.
- **Push.** A push is requested in every cycle where `pedge != 0`.
  - The record is {`pedge`, `ts`} as sampled in that cycle.
  - `pedge == 0` never writes.
- **Pop.** A pop occurs when `out_valid && out_ready`. `out_ready` is ignored while `out_valid` is 0.
- **Full FIFO** (`level == DEPTH`):
  - A push with no pop in the same cycle is dropped. `overflow` is set to 1 and `drop_cnt` increments, saturating at 255.
  - A push together with a pop is accepted. `level` stays at DEPTH and no drop is recorded.
- **Empty FIFO.** A push with `out_ready` high is not bypassed. The record appears on the outputs first and pops in a later cycle.
- **Level update.** `level` changes by +1 (push only), −1 (pop only), or 0 (both, or neither).
- **Read/write pointers.** These are $clog2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty, and both pointers wrap naturally.
- **Output ordering.** Records are output in strict arrival order.
- **Idle outputs.** `out_mask` and `out_ts` are driven to 0 whenever `out_valid` is 0.
- **Overflow clear.**
  - `ovf_clr` clears `overflow` and `drop_cnt` to 0.
  - If a drop happens in the same cycle as `ovf_clr`, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- **Reset.** Asserting `rst`, including in the middle of traffic, immediately discards all contents. Resulting values:
  - `out_valid` = 0, `out_mask` = 0, `out_ts` = 0, `level` = 0.
  - `overflow` = 0, `drop_cnt` = 0.
  - `ts` = 0 and both pointers = 0.

## Timing
- **Push-to-output latency:** 1 cycle. A push at edge N is visible on `out_valid`/`out_mask`/`out_ts` after edge N and stable through edge N+1.
- **Pop behaviour:** a pop at edge N presents the next record, or `out_valid` = 0, after edge N.
- **Output stability:** `out_mask` and `out_ts` are held stable while `out_valid && !out_ready`.
- **`level`, `overflow`, `drop_cnt`:** registered, and they reflect the events of the previous edge.
- **Throughput:** one push and one pop per cycle, sustained.
- **Combinational paths:** none from `out_ready` or `pedge` to any output.

## Test plan
- **Reset and basic capture.** Release `rst`, keep `out_ready` = 0, drive `pedge` = 8'h05 for one cycle at `ts` = 3.
  - Required: one cycle later `out_valid` = 1, `out_mask` = 8'h05, `out_ts` = 3, `level` = 1.
  - Then raise `out_ready` for one cycle; required: `out_valid` = 0, `out_mask` = 0, `level` = 0.
- **Ordering and throughput.** With `out_ready` held at 1, drive `pedge` = 01, 02, 04, 08 on consecutive cycles starting at `ts` = 10.
  - Required: outputs {01,10}, {02,11}, {04,12}, {08,13} on consecutive cycles.
  - `level` never exceeds 1.
- **Fill and overflow.** With `out_ready` = 0 (DEPTH = 8), drive 11 consecutive nonzero `pedge` values.
  - Required: `level` = 8, `overflow` = 1, `drop_cnt` = 3.
  - The FIFO holds the first 8 records in order.
- **Full with simultaneous push and pop.** Starting from full, drive `pedge` = 8'hFF with `out_ready` = 1.
  - Required: `level` stays 8, `drop_cnt` is unchanged, and 8'hFF appears as the 8th subsequent output.
- **Clear collides with a drop.** While full and `drop_cnt` = 3, pulse `ovf_clr` in the same cycle as a dropped push.
  - Required: `overflow` = 1, `drop_cnt` = 1.
  - A later `ovf_clr` with no drop gives 0/0.
  - Also drop 260 events with no clear; required: `drop_cnt` = 255.
- **Reset mid-stream and timestamp wrap.**
  - With `level` = 5, assert `rst` for one cycle. Required: `level` = 0, `out_valid` = 0, and `ts` restarts at 0.
  - With TS_W = 4, push on the cycles where `ts` = 15 and `ts` = 0. Required: `out_ts` = 15, then `out_ts` = 0.

Source files
------------

// File: rtl/edge_event_fifo.sv
// Time-stamped event FIFO fed by a per-bit rising-edge detector.
// Every nonzero pedge cycle becomes one {mask, ts} record; pushes into a full FIFO are dropped and counted.
module edge_event_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int TS_W  = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pedge,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mask,
   output logic [TS_W-1:0]  out_ts,
   output logic [LW-1:0]    level,
   output logic             overflow,
   output logic [7:0]       drop_cnt,
   input  logic             ovf_clr
);

   logic [TS_W-1:0]  r_ts;
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem_mask [DEPTH];
   logic [TS_W-1:0]  r_mem_ts   [DEPTH];
   logic             r_overflow;
   logic [7:0]       r_drop_cnt;

   logic [LW-1:0]    w_level;
   logic             w_empty;
   logic             w_full;
   logic             w_req;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // Pointers carry one extra MSB, so their difference is the fill level 0..DEPTH.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == LW'(DEPTH));
   assign w_req   = |pedge;
   assign w_pop   = !w_empty && out_ready;
   assign w_push  = w_req && (!w_full || w_pop);
   assign w_drop  = w_req && w_full && !w_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ts     <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: stale entries are never visible because outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_mask[r_wr_ptr[AW-1:0]] <= pedge;
         r_mem_ts[r_wr_ptr[AW-1:0]]   <= r_ts;
      end
   end

   // A drop in the same cycle as a clear restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (ovf_clr)                 r_drop_cnt <= 8'd1;
         else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   assign out_valid = !w_empty;
   assign out_mask  = out_valid ? r_mem_mask[r_rd_ptr[AW-1:0]] : '0;
   assign out_ts    = out_valid ? r_mem_ts[r_rd_ptr[AW-1:0]]   : '0;
   assign level     = w_level;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

endmodule
